// File: rtl/judge_pkg.sv
// Types and constants shared by the judge_gather collection blocks.
package judge_pkg;

  // Top-level collection round states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Largest supported channel count
  localparam int MAX_CH = 32;

endpackage

// File: rtl/judge_gather_tmo_counter.sv
// Loadable saturating cycle counter with a programmable expiry compare.
// A load value of zero disables expiry.
module tmo_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] tmo_q, tmo_d;

  // Next count: load/clear restart from zero, enable counts up and sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    if (load_i) begin
      cnt_d = '0;
      tmo_d = load_val_i;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count and limit registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  // Expire on the cycle whose count is one short of the limit, so the
  // consumer's registered response lands exactly limit cycles in
  assign expire_o = (tmo_q != '0) && (cnt_q == (tmo_q - W'(1)));

endmodule

// File: rtl/judge_gather.sv
// Gathers per-channel finish pulses for the channels enabled at start and
// reports one qualified completion (all or any) with optional timeout.
module judge_gather
  import judge_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int TMO_W    = 16,
  parameter bit MODE_ANY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_CH-1:0]  judge,
  input  logic [N_CH-1:0]  finish,
  input  logic [TMO_W-1:0] timeout_cyc,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [N_CH-1:0]  done_mask,
  output logic             timed_out
);

  if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_n_ch
    $error("judge_gather: N_CH out of range");
  end

  state_t          state_q, state_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [N_CH-1:0] sticky_q, sticky_d;
  logic [N_CH-1:0] done_mask_q, done_mask_d;
  logic            timed_out_q, timed_out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept;
  logic            ctr_clr;
  logic            expire;
  logic [N_CH-1:0] sticky_nxt;
  logic            met;

  assign accept  = (state_q == IDLE) && start;
  assign ctr_clr = (state_q == DONE) && ack;

  tmo_counter #(.W(TMO_W)) u_tmo (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (ctr_clr),
    .load_i     (accept),
    .load_val_i (timeout_cyc),
    .en_i       (state_q == COLLECT),
    .expire_o   (expire)
  );

  // Completion qualifier over the finishes seen so far plus this cycle's
  always_comb begin
    sticky_nxt = sticky_q | (finish & mask_q);
    if (MODE_ANY) met = |sticky_nxt;
    else          met = ((sticky_nxt & mask_q) == mask_q);
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    sticky_d    = sticky_q;
    done_mask_d = done_mask_q;
    timed_out_d = timed_out_q;
    busy_d      = busy_q;
    done_d      = done_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mask_d   = judge;
          sticky_d = '0;
          busy_d   = 1'b1;
          if (judge == '0) begin
            // Empty round has nothing to wait for
            state_d     = DONE;
            done_d      = 1'b1;
            done_mask_d = '0;
            timed_out_d = 1'b0;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        sticky_d = sticky_nxt;
        if (met || expire) begin
          // A finish on the expire cycle still counts as a clean completion
          state_d     = DONE;
          done_d      = 1'b1;
          done_mask_d = sticky_nxt;
          timed_out_d = !met;
        end
      end
      DONE: begin
        if (ack) begin
          state_d     = IDLE;
          done_d      = 1'b0;
          busy_d      = 1'b0;
          done_mask_d = '0;
          timed_out_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      sticky_q    <= '0;
      done_mask_q <= '0;
      timed_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      sticky_q    <= sticky_d;
      done_mask_q <= done_mask_d;
      timed_out_q <= timed_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign done_mask = done_mask_q;
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_judge_gather.sv
// Directed bench for judge_gather: an ALL-mode and an ANY-mode instance see
// the same stimulus and are compared every cycle against a round-level model.
module tb_judge_gather;

  localparam int N  = 4;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  judge = '0;
  logic [N-1:0]  finish = '0;
  logic [TW-1:0] timeout_cyc = '0;
  logic          ack = 1'b0;

  logic          busy_a, done_a, to_a;
  logic [N-1:0]  dm_a;
  logic          busy_y, done_y, to_y;
  logic [N-1:0]  dm_y;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  judge_gather #(.N_CH(N), .TMO_W(TW), .MODE_ANY(1'b0)) u_all (
    .clk(clk), .rst(rst), .start(start), .judge(judge), .finish(finish),
    .timeout_cyc(timeout_cyc), .ack(ack),
    .busy(busy_a), .done(done_a), .done_mask(dm_a), .timed_out(to_a)
  );

  judge_gather #(.N_CH(N), .TMO_W(TW), .MODE_ANY(1'b1)) u_any (
    .clk(clk), .rst(rst), .start(start), .judge(judge), .finish(finish),
    .timeout_cyc(timeout_cyc), .ack(ack),
    .busy(busy_y), .done(done_y), .done_mask(dm_y), .timed_out(to_y)
  );

  // Round-level model: a round is active from an accepted start until ack;
  // elapsed counts collecting cycles as a plain integer.
  typedef struct {
    bit           act;
    bit           dn;
    bit           to;
    logic [N-1:0] msk;
    logic [N-1:0] seen;
    logic [N-1:0] dmask;
    int           tmo;
    int           el;
  } mdl_t;

  mdl_t m_all, m_any;

  function automatic mdl_t mreset();
    mdl_t r;
    r.act = 0; r.dn = 0; r.to = 0; r.msk = '0; r.seen = '0; r.dmask = '0;
    r.tmo = 0; r.el = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t s, bit any, bit st, logic [N-1:0] j,
                                 int tc, logic [N-1:0] f, bit a);
    mdl_t r = s;
    bit fin, exp_now;
    if (!s.act) begin
      if (st) begin
        r = mreset();
        r.act = 1; r.msk = j; r.tmo = tc;
        r.dn = (j == '0);
      end
    end else if (s.dn) begin
      if (a) r = mreset();
    end else begin
      r.seen  = s.seen | (f & s.msk);
      fin     = any ? (r.seen != '0) : (r.seen == s.msk);
      exp_now = (s.tmo != 0) && (s.el + 1 == s.tmo);
      r.el    = s.el + 1;
      if (fin || exp_now) begin
        r.dn = 1; r.dmask = r.seen; r.to = !fin;
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_all = mreset();
      m_any = mreset();
    end else begin
      m_all = mstep(m_all, 1'b0, start, judge, int'(timeout_cyc), finish, ack);
      m_any = mstep(m_any, 1'b1, start, judge, int'(timeout_cyc), finish, ack);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare of both instances against the model
  always @(negedge clk) begin
    chk("all.busy", 32'(busy_a), 32'(m_all.act));
    chk("all.done", 32'(done_a), 32'(m_all.act && m_all.dn));
    chk("all.mask", 32'(dm_a),   32'(m_all.dn ? m_all.dmask : '0));
    chk("all.to",   32'(to_a),   32'(m_all.dn && m_all.to));
    chk("any.busy", 32'(busy_y), 32'(m_any.act));
    chk("any.done", 32'(done_y), 32'(m_any.act && m_any.dn));
    chk("any.mask", 32'(dm_y),   32'(m_any.dn ? m_any.dmask : '0));
    chk("any.to",   32'(to_y),   32'(m_any.dn && m_any.to));
  end

  // Drive one cycle of inputs (from a negedge), pulses cleared afterwards
  task automatic cyc(input logic s, input logic [N-1:0] j, input int tc,
                     input logic [N-1:0] f, input logic a);
    start = s; judge = j; timeout_cyc = TW'(tc); finish = f; ack = a;
    @(negedge clk);
    #1;
    start = 1'b0; finish = '0; ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, judge, int'(timeout_cyc), '0, 1'b0);
  endtask

  task automatic ack_all();
    cyc(1'b0, judge, 0, '0, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset.busy", 32'(busy_a), 0);
    chk("reset.done", 32'(done_a | done_y), 0);
    rst = 1'b0;
    idle(2);

    // ALL mode: ch0 t3, ch3 t5, ch1 t9 -> done at t10
    cyc(1'b1, 4'b1011, 0, '0, 1'b0);           // now in t0
    idle(3);                                    // t0..t2
    cyc(1'b0, 4'b1011, 0, 4'b0001, 1'b0);       // t3
    chk("any.first.done", 32'(done_y), 1);
    chk("any.first.mask", 32'(dm_y), 32'h1);
    idle(1);                                    // t4
    cyc(1'b0, 4'b1011, 0, 4'b1000, 1'b0);       // t5
    idle(3);                                    // t6..t8
    chk("all.t9.notdone", 32'(done_a), 0);
    cyc(1'b0, 4'b1011, 0, 4'b0010, 1'b0);       // t9
    chk("all.t10.done", 32'(done_a), 1);
    chk("all.t10.mask", 32'(dm_a), 32'hB);
    chk("all.t10.to", 32'(to_a), 0);
    // Hold 20 cycles without ack, stray finishes and starts ignored
    for (int i = 0; i < 20; i++)
      cyc(i[2], 4'b0100, 3, (i % 3 == 0) ? 4'b1111 : 4'b0000, 1'b0);
    chk("hold.mask", 32'(dm_a), 32'hB);
    chk("hold.busy", 32'(busy_a), 1);
    // ack with start: back to IDLE, no new round
    cyc(1'b1, 4'b1111, 0, '0, 1'b1);
    chk("ackstart.busy", 32'(busy_a | busy_y), 0);
    idle(2);

    // Out-of-mask then simultaneous in-mask finishes
    cyc(1'b1, 4'b0011, 0, '0, 1'b0);
    cyc(1'b0, 4'b0011, 0, 4'b1100, 1'b0);
    chk("oom.notdone", 32'(done_a | done_y), 0);
    cyc(1'b0, 4'b0011, 0, 4'b0011, 1'b0);
    chk("simul.mask", 32'(dm_a), 32'h3);
    ack_all();
    idle(1);

    // Timeout 8, only ch1 of 0110 finishes
    cyc(1'b1, 4'b0110, 8, '0, 1'b0);            // t0
    idle(1);                                    // t0
    cyc(1'b0, 4'b0110, 8, 4'b0010, 1'b0);       // t1
    idle(5);                                    // t2..t6
    chk("tmo.t7.notdone", 32'(done_a), 0);
    idle(1);                                    // t7
    chk("tmo.done", 32'(done_a), 1);
    chk("tmo.to", 32'(to_a), 1);
    chk("tmo.mask", 32'(dm_a), 32'h2);
    ack_all();
    idle(1);

    // Tie: last finish on the expire cycle (tmo=4, t3)
    cyc(1'b1, 4'b0011, 4, '0, 1'b0);
    cyc(1'b0, 4'b0011, 4, 4'b0001, 1'b0);       // t0
    idle(2);                                    // t1..t2
    cyc(1'b0, 4'b0011, 4, 4'b0010, 1'b0);       // t3
    chk("tie.done", 32'(done_a), 1);
    chk("tie.to", 32'(to_a), 0);
    ack_all();
    idle(1);

    // tmo=1 expires after one cycle
    cyc(1'b1, 4'b1000, 1, '0, 1'b0);
    idle(1);
    chk("tmo1.to", 32'(to_a & to_y), 1);
    ack_all();
    idle(1);

    // ANY mode: first enabled finish on ch2
    cyc(1'b1, 4'b0110, 0, '0, 1'b0);
    idle(2);
    cyc(1'b0, 4'b0110, 0, 4'b0100, 1'b0);
    chk("any.ch2.mask", 32'(dm_y), 32'h4);
    chk("any.ch2.alldone", 32'(done_a), 0);
    cyc(1'b0, 4'b0110, 0, 4'b0010, 1'b0);
    ack_all();
    idle(1);

    // Empty judge completes the cycle after start
    cyc(1'b1, 4'b0000, 0, '0, 1'b0);
    chk("empty.done", 32'(done_a), 1);
    chk("empty.mask", 32'(dm_a), 0);
    ack_all();
    idle(1);

    // Asynchronous reset mid-COLLECT
    cyc(1'b1, 4'b1111, 0, '0, 1'b0);
    cyc(1'b0, 4'b1111, 0, 4'b0001, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", 32'(busy_a | busy_y), 0);
    chk("arst.done", 32'(done_a | done_y | to_a | to_y), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 4'b1111, 0, 4'b1111, 1'b0);
    cyc(1'b0, 4'b1111, 0, 4'b1111, 1'b0);
    chk("postrst.idle", 32'(busy_a | done_a | busy_y), 0);
    cyc(1'b1, 4'b0001, 0, '0, 1'b0);
    cyc(1'b0, 4'b0001, 0, 4'b0001, 1'b0);
    chk("fresh.mask", 32'(dm_a), 32'h1);
    ack_all();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
